obstacle_painter: RTL and testbench
===================================

Name: obstacle_painter

Overview:
- Write-side engine for the image_ram obstacle memory. The obstacle datapath only reads this memory; this block writes it.
- Accepts a rectangle-fill command and streams one pixel write per clock into image_ram's write port (x_write, y_write, color_in, wren).
- Lets the game controller draw, clear or erase obstacles at run time on the 160x120 playfield.

Parameters:
- XRES, 160, horizontal playfield size in pixels; x coordinates valid 0..XRES-1.
- YRES, 120, vertical playfield size in pixels; y coordinates valid 0..YRES-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only while busy=0.
- x0  in  8  rectangle left column.
- y0  in  7  rectangle top row.
- w  in  8  rectangle width in pixels.
- h  in  7  rectangle height in pixels.
- color  in  3  fill colour; 3'b000 erases an obstacle.
- abort  in  1  cancels an in-progress fill.
- busy  out  1  high while the fill is active.
- done  out  1  one-cycle pulse when a fill completes normally.
- x_write  out  8  image_ram write column (registered).
- y_write  out  7  image_ram write row (registered).
- color_in  out  3  image_ram write data (registered).
- wren  out  1  image_ram write enable (registered).

Behaviour:
- Reset, asynchronous: state=IDLE; busy, done, wren, x_write, y_write and color_in all 0. Reset mid-fill kills the fill at once; no done pulse; no further writes.
- FSM states:
  - IDLE: busy=0, wren=0.
  - FILL: busy=1, wren=1.
  - FIN: one cycle; done=1, busy=0, wren=0; then returns to IDLE.
- Command acceptance: start=1 with busy=0 (IDLE or FIN) at edge N latches x0, y0, color, x_end and y_end.
  - x_end = min(x0+w, XRES), computed 9 bits wide. y_end = min(y0+h, YRES), computed 8 bits wide. No wrap-around; the rectangle is clipped to the playfield.
- Empty command: w=0, h=0, x0>=XRES or y0>=YRES. Go straight to FIN; done is high in cycle N+1; no writes.
- Normal command:
  - Cycle N+1: state=FILL, wren=1, (x_write, y_write) = (x0, y0).
  - Each following cycle x_write increments. When x_write = x_end-1, it reloads x0 and y_write increments.
  - The last write is (x_end-1, y_end-1) in cycle N+P, where P = (x_end-x0)*(y_end-y0).
  - Cycle N+P+1: FIN with done=1. Cycle N+P+2: IDLE, unless a new start was accepted in FIN.
- Writes are row-major, one pixel per cycle, with no gaps. color_in holds the latched colour for the whole fill.
- start while busy=1 is ignored; it is neither queued nor latched. Input changes during FILL have no effect.
- abort=1 in FILL at edge M: next state IDLE; wren=0 from cycle M+1; no done. The write shown in cycle M is the last one performed.
- abort=1 together with an accepted start (state IDLE or FIN) is ignored; start wins. abort in IDLE or FIN has no effect.
- image_ram latency is not visible here. Outputs are registered and the RAM write commits on the edge after wren is seen.

Test Plan:
- Reset then idle, 10 cycles -> busy=0, done=0, wren=0, address and data outputs all 0.
- Fill x0=10, y0=20, w=3, h=2, color=3'b010:
  - Writes (10,20), (11,20), (12,20), (10,21), (11,21), (12,21) in cycles N+1..N+6.
  - done=1 in cycle N+7 only. Read-back through a second image_ram port returns 3'b010 at all six points and 0 at (13,20).
- Clipping, x0=158, y0=118, w=5, h=5:
  - Exactly 4 writes: (158,118), (159,118), (158,119), (159,119).
  - done at N+5; no write with x>=160 or y>=120.
- Empty commands: w=0 -> done at N+1, no wren. x0=200 -> same result.
- start asserted during a fill -> ignored; write count is unchanged. start in the FIN cycle -> new fill begins with its first write at FIN+1.
- abort after the 3rd write of a 4x4 fill -> only 3 writes, no done, busy=0 the next cycle. Async reset asserted mid-fill -> wren=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/obstacle_painter.sv
// Rectangle-fill write engine for the image_ram obstacle memory.
// Streams one clipped, row-major pixel write per clock into the RAM write port.
module obstacle_painter #(
    parameter int XRES = 160,
    parameter int YRES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [7:0] w,
    input  logic [6:0] h,
    input  logic [2:0] color,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [7:0] x_write,
    output logic [6:0] y_write,
    output logic [2:0] color_in,
    output logic       wren
);

    localparam logic [8:0] XRES_9 = 9'(XRES);
    localparam logic [7:0] YRES_8 = 8'(YRES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [7:0] x_first_q;
    logic [7:0] x_last_q;
    logic [6:0] y_last_q;

    logic [8:0] x_sum, x_end;
    logic [7:0] y_sum, y_end;
    logic [7:0] x_last_d;
    logic [6:0] y_last_d;
    logic       cmd_empty;
    logic       accept;
    logic       at_last_col;
    logic       at_last_row;

    // Handshake: start is taken on any edge where busy=0 (IDLE or FIN); while
    // busy=1 start is ignored, never queued. abort only matters in FILL.
    assign accept = start && (state_q != S_FILL);

    // Clip to the playfield; sums are one bit wider than the operands so they never wrap.
    assign x_sum    = {1'b0, x0} + {1'b0, w};
    assign y_sum    = {1'b0, y0} + {1'b0, h};
    assign x_end    = (x_sum > XRES_9) ? XRES_9 : x_sum;
    assign y_end    = (y_sum > YRES_8) ? YRES_8 : y_sum;
    assign x_last_d = 8'(x_end - 9'd1);
    assign y_last_d = 7'(y_end - 8'd1);

    assign cmd_empty = (w == 8'd0) || (h == 7'd0) ||
                       ({1'b0, x0} >= XRES_9) || ({1'b0, y0} >= YRES_8);

    assign at_last_col = (x_write == x_last_q);
    assign at_last_row = (y_write == y_last_q);

    assign busy = (state_q == S_FILL);
    assign wren = (state_q == S_FILL);
    assign done = (state_q == S_FIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (start) begin
                    state_d = cmd_empty ? S_FIN : S_FILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (at_last_col && at_last_row) begin
                    state_d = S_FIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_write   <= 8'd0;
            y_write   <= 7'd0;
            color_in  <= 3'd0;
            x_first_q <= 8'd0;
            x_last_q  <= 8'd0;
            y_last_q  <= 7'd0;
        end else if (accept) begin
            x_write   <= x0;
            y_write   <= y0;
            color_in  <= color;
            x_first_q <= x0;
            x_last_q  <= x_last_d;
            y_last_q  <= y_last_d;
        end else if (state_q == S_FILL && !abort && !(at_last_col && at_last_row)) begin
            // Row-major scan: wrap to the left edge at the end of each row.
            if (at_last_col) begin
                x_write <= x_first_q;
                y_write <= y_write + 7'd1;
            end else begin
                x_write <= x_write + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_obstacle_painter.sv
// Bench for obstacle_painter: directed cases plus randomized fills checked
// against a pixel-list reference and a shadow image of the playfield.
module tb_obstacle_painter;

    localparam int XRES = 160;
    localparam int YRES = 120;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] w;
    logic [6:0] h;
    logic [2:0] color;
    logic       abort;
    logic       busy;
    logic       done;
    logic [7:0] x_write;
    logic [6:0] y_write;
    logic [2:0] color_in;
    logic       wren;

    int n_cmp;
    int n_bad;
    int last_writes;

    logic [17:0] exp_q[$];
    logic [2:0]  dut_img [0:127][0:255];
    logic [2:0]  ref_img [0:127][0:255];

    obstacle_painter #(.XRES(XRES), .YRES(YRES)) dut (
        .clk(clk), .reset(reset), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
        .color(color), .abort(abort), .busy(busy), .done(done), .x_write(x_write),
        .y_write(y_write), .color_in(color_in), .wren(wren)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // image_ram model: the write lands on the edge where wren is seen
    always @(posedge clk) begin
        if (wren === 1'b1) dut_img[y_write][x_write] = color_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        abort = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("idle_ctl", {29'd0, busy, done, wren}, 32'd0);
        end
    endtask

    // Issue a command at the current negedge and follow it to done or abort.
    // abort_at=k raises abort in the cycle showing the k-th write.
    task automatic do_fill(input int ax0, input int ay0, input int aw, input int ah,
                           input logic [2:0] ac, input int abort_at, input bit noise);
        int xe, ye, k;
        logic [17:0] px;
        xe = (ax0 + aw > XRES) ? XRES : ax0 + aw;
        ye = (ay0 + ah > YRES) ? YRES : ay0 + ah;
        exp_q.delete();
        for (int y = ay0; y < ye; y++)
            for (int x = ax0; x < xe; x++)
                exp_q.push_back({8'(x), 7'(y), ac});
        start = 1'b1;
        abort = 1'b0;
        x0 = 8'(ax0); y0 = 7'(ay0); w = 8'(aw); h = 7'(ah); color = ac;
        k = 0;
        while (1) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (exp_q.size() == 0) begin
                check("done_ctl", {29'd0, busy, done, wren}, 32'b010);
                break;
            end
            px = exp_q.pop_front();
            check("fill_ctl", {29'd0, busy, done, wren}, 32'b101);
            check("pixel", {14'd0, x_write, y_write, color_in}, {14'd0, px});
            ref_img[px[9:3]][px[17:10]] = px[2:0];
            k++;
            if (k == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_ctl", {29'd0, busy, done, wren}, 32'd0);
                break;
            end
            if (noise && $urandom_range(0, 1) == 0) begin
                start = 1'b1;
                x0 = 8'($urandom); y0 = 7'($urandom); w = 8'($urandom_range(0, 9));
                h = 7'($urandom_range(0, 9)); color = 3'($urandom);
            end
        end
        last_writes = k;
    endtask

    initial begin
        int diffs;
        n_cmp = 0;
        n_bad = 0;
        for (int y = 0; y < 128; y++)
            for (int x = 0; x < 256; x++) begin
                dut_img[y][x] = 3'd0;
                ref_img[y][x] = 3'd0;
            end
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        x0 = 8'd0; y0 = 7'd0; w = 8'd0; h = 7'd0; color = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state, then quiet idle
        @(negedge clk);
        check("rst_outputs", {14'd0, x_write, y_write, color_in}, 32'd0);
        idle(10);

        // basic 3x2 fill and read-back
        do_fill(10, 20, 3, 2, 3'b010, -1, 0);
        check("fill1_writes", last_writes, 6);
        idle(1);
        for (int y = 20; y < 22; y++)
            for (int x = 10; x < 13; x++)
                check("rb_fill1", {29'd0, dut_img[y][x]}, 32'b010);
        check("rb_outside", {29'd0, dut_img[20][13]}, 32'd0);

        // clipping at the bottom-right corner
        do_fill(158, 118, 5, 5, 3'b101, -1, 0);
        check("clip_writes", last_writes, 4);
        idle(2);

        // empty commands
        do_fill(40, 40, 0, 3, 3'b111, -1, 0);
        check("empty_w", last_writes, 0);
        idle(1);
        do_fill(200, 10, 4, 4, 3'b111, -1, 0);
        check("empty_x", last_writes, 0);
        idle(1);

        // start during fill ignored; start in FIN chains immediately
        do_fill(50, 60, 4, 3, 3'b011, -1, 1);
        check("noise_writes", last_writes, 12);
        do_fill(70, 5, 2, 2, 3'b100, -1, 0);
        idle(2);

        // abort after the 3rd write of a 4x4 fill
        do_fill(90, 90, 4, 4, 3'b110, 3, 0);
        check("abort_writes", last_writes, 3);
        idle(3);

        // asynchronous reset in the middle of a fill
        start = 1'b1; x0 = 8'd30; y0 = 7'd30; w = 8'd4; h = 7'd4; color = 3'b001;
        @(negedge clk);
        start = 1'b0;
        check("ar_first", {14'd0, x_write, y_write, color_in}, {14'd0, 8'd30, 7'd30, 3'b001});
        ref_img[30][30] = 3'b001;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("ar_wren", {31'd0, wren}, 32'd0);
        check("ar_busy", {31'd0, busy}, 32'd0);
        check("ar_xw", {24'd0, x_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(3);

        // randomized fills
        for (int i = 0; i < 30; i++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1;
            do_fill($urandom_range(0, 165), $urandom_range(0, 125), $urandom_range(0, 14),
                    $urandom_range(0, 6), 3'($urandom), ab, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        diffs = 0;
        for (int y = 0; y < 128; y++)
            for (int x = 0; x < 256; x++)
                if (dut_img[y][x] !== ref_img[y][x]) diffs++;
        check("image_diffs", diffs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
